// File: rtl/key_event_arbiter.sv
// Turns debounced key levels into PRESS/LONG/REPEAT/RELEASE events and
// serialises them, round-robin, through a small valid/ready event FIFO.
module key_event_arbiter #(
  parameter int N_KEYS     = 4,
  parameter int KEY_W      = 2,
  parameter int CNT_W      = 26,
  parameter int LONG_TH    = 50000000,
  parameter int REP_TH     = 10000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_lvl,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [KEY_W-1:0]  ev_key,
  output logic [1:0]        ev_code,
  output logic              overflow,
  input  logic              ovf_clr
);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_LONG    = 2'b01,
    EV_REPEAT  = 2'b10,
    EV_RELEASE = 2'b11
  } ev_code_e;

  typedef enum logic [1:0] {IDLE, HELD, RPT} key_state_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    ev_code_e         code;
  } fifo_entry_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TH - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REP_TH - 1);

  logic [N_KEYS-1:0] lvl_q, rise, fall;
  key_state_e        state [N_KEYS];
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [N_KEYS-1:0] raise, load, drop;
  ev_code_e          raise_code [N_KEYS];
  logic [N_KEYS-1:0] pend_v;
  ev_code_e          pend_code [N_KEYS];
  logic [KEY_W-1:0]  rr;
  logic              grant_v;
  logic [KEY_W-1:0]  grant_idx;
  logic [N_KEYS-1:0] gnt;
  fifo_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_FW-1:0] count;
  logic              fifo_full, push, pop;

  assign rise = key_lvl & ~lvl_q;
  assign fall = ~key_lvl & lvl_q;

  // Events are decided combinationally so they reach the pending slot on the same edge.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
      raise[i]      = 1'b0;
      raise_code[i] = EV_PRESS;
      case (state[i])
        IDLE: if (rise[i]) raise[i] = 1'b1;
        HELD: begin
          if (fall[i]) begin
            raise[i] = 1'b1; raise_code[i] = EV_RELEASE;
          end else if (cnt[i] == LONG_M1) begin
            raise[i] = 1'b1; raise_code[i] = EV_LONG;
          end
        end
        RPT: begin
          if (fall[i]) begin
            raise[i] = 1'b1; raise_code[i] = EV_RELEASE;
          end else if (cnt[i] == REP_M1) begin
            raise[i] = 1'b1; raise_code[i] = EV_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      lvl_q <= key_lvl;
      for (int i = 0; i < N_KEYS; i++) begin
        case (state[i])
          IDLE: if (rise[i]) begin
            cnt[i]   <= '0;
            state[i] <= HELD;
          end
          HELD: begin
            if (fall[i]) state[i] <= IDLE;
            else if (cnt[i] == LONG_M1) begin
              cnt[i]   <= '0;
              state[i] <= RPT;
            end else cnt[i] <= cnt[i] + CNT_W'(1);
          end
          RPT: begin
            if (fall[i]) state[i] <= IDLE;
            else if (cnt[i] == REP_M1) cnt[i] <= '0;
            else cnt[i] <= cnt[i] + CNT_W'(1);
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Circular search from rr; no grant at all while the FIFO is full.
  always_comb begin : arb
    int k;
    grant_v   = 1'b0;
    grant_idx = '0;
    gnt       = '0;
    k         = 0;
    if (!fifo_full) begin
      for (int j = 0; j < N_KEYS; j++) begin
        k = (int'(rr) + j) % N_KEYS;
        if (!grant_v && pend_v[k]) begin
          grant_v   = 1'b1;
          grant_idx = KEY_W'(k);
          gnt[k]    = 1'b1;
        end
      end
    end
  end

  assign drop = raise & pend_v & ~gnt;
  assign load = raise & ~drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v   <= '0;
      rr       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) pend_code[i] <= EV_PRESS;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (load[i]) begin
          pend_v[i]    <= 1'b1;
          pend_code[i] <= raise_code[i];
        end else if (gnt[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (grant_v) rr <= KEY_W'((int'(grant_idx) + 1) % N_KEYS);
      if (|drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign fifo_full = (count == CNT_FW'(FIFO_DEPTH));
  assign push      = grant_v;
  assign pop       = ev_valid & ev_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_FW'(1);
        2'b01:   count <= count - CNT_FW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only visible once written and counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{key: grant_idx, code: pend_code[grant_idx]};
  end

  assign ev_valid = (count != '0);
  assign ev_key   = ev_valid ? mem[rd_ptr].key : '0;
  assign ev_code  = ev_valid ? mem[rd_ptr].code : EV_PRESS;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed tables/sequences plus random stimulus
// compared every cycle against a queue-based behavioural model.
module tb_key_event_arbiter;

  localparam int N = 4;
  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_lvl = '0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic [1:0] ev_code;
  logic       overflow;

  always #5 clk = ~clk;

  key_event_arbiter #(
    .N_KEYS(N), .KEY_W(2), .CNT_W(8), .LONG_TH(L), .REP_TH(R), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_key(ev_key), .ev_code(ev_code),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  typedef struct { int key; int code; } ev_t;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  ev_t mq[$];
  bit  m_prev[N];
  int  m_age[N];
  bit  m_pv[N];
  int  m_pc[N];
  int  m_rr;
  bit  m_ovf;

  // transfers observed in directed scenarios
  ev_t obs[$];
  bit  rec = 1'b0;

  function automatic ev_t mk(input int k, input int c);
    ev_t e;
    e.key = k;
    e.code = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] l, input logic r, input logic c, input logic n);
    int g;
    int ev;
    bit dropped;
    g = -1;
    dropped = 1'b0;
    if (!n) begin
      mq.delete();
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1'b0; m_age[i] = 0; m_pv[i] = 1'b0; m_pc[i] = 0;
      end
      m_rr = 0;
      m_ovf = 1'b0;
      return;
    end
    if (mq.size() < D) begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && m_pv[(m_rr + j) % N]) g = (m_rr + j) % N;
      end
    end
    if (r && mq.size() != 0) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back(mk(g, m_pc[g]));
      m_pv[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      ev = -1;
      if (l[i] && !m_prev[i]) begin
        ev = 0;
        m_age[i] = 0;
      end else if (!l[i] && m_prev[i]) begin
        ev = 3;
      end else if (m_prev[i]) begin
        m_age[i]++;
        if (m_age[i] == L) ev = 1;
        else if (m_age[i] > L && (m_age[i] - L) % R == 0) ev = 2;
      end
      if (ev >= 0) begin
        if (!m_pv[i]) begin
          m_pv[i] = 1'b1;
          m_pc[i] = ev;
        end else dropped = 1'b1;
      end
      m_prev[i] = l[i];
    end
    if (dropped) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    logic mv;
    mv = (mq.size() != 0);
    check("mdl_valid", ev_valid, mv);
    check("mdl_overflow", overflow, m_ovf);
    if (ev_valid && mv) begin
      check("mdl_key", ev_key, mq[0].key);
      check("mdl_code", ev_code, mq[0].code);
    end
  endtask

  task automatic step(input logic [3:0] l, input logic r, input logic c, input logic n);
    key_lvl = l; ev_ready = r; ovf_clr = c; rst_n = n;
    #1;
    if (rec && rst_n && ev_valid && ev_ready) obs.push_back(mk(ev_key, ev_code));
    @(posedge clk);
    model_edge(l, r, c, n);
    #1;
    compare_model();
  endtask

  task automatic check_obs(input string nm, input ev_t exp[$]);
    check({nm, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      check({nm, "_key"}, obs[i].key, exp[i].key);
      check({nm, "_code"}, obs[i].code, exp[i].code);
    end
  endtask

  typedef struct {
    logic [3:0] lvl;
    logic       rdy;
    logic       v;
    logic [1:0] key;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[12];
  int   a_at[6]  = '{1, 9, 13, 17, 21, 22};
  int   a_cd[6]  = '{0, 1, 2, 2, 2, 3};

  initial begin
    ev_t exp_q[$];
    logic exp_v;
    int   exp_c;
    logic [3:0] lv;
    int   rdy_pct;

    // simultaneous press burst then simultaneous release burst, ready=1
    for (int i = 0; i < 12; i++) begin
      tbl[i].lvl = (i < 6) ? 4'b1111 : 4'b0000;
      tbl[i].rdy = 1'b1;
      tbl[i].v   = (i >= 1 && i <= 4) || (i >= 7 && i <= 10);
      tbl[i].key = (i >= 7) ? 2'(i - 7) : 2'(i - 1);
      tbl[i].code = (i >= 6) ? 2'b11 : 2'b00;
    end

    // reset state
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_key", ev_key, 2'd0);
    check("rst_code", ev_code, 2'd0);
    check("rst_overflow", overflow, 1'b0);

    // A: long hold on key0, ready=1
    for (int s = 0; s < 28; s++) begin
      step((s <= 20) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, 1'b1);
      exp_v = 1'b0;
      exp_c = 0;
      for (int k = 0; k < 6; k++) if (a_at[k] == s) begin exp_v = 1'b1; exp_c = a_cd[k]; end
      check("A_valid", ev_valid, exp_v);
      if (exp_v) begin
        check("A_key", ev_key, 2'd0);
        check("A_code", ev_code, exp_c);
      end
    end
    check("A_overflow", overflow, 1'b0);

    // B: table-driven burst
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].lvl, tbl[i].rdy, 1'b0, 1'b1);
      check("B_valid", ev_valid, tbl[i].v);
      if (tbl[i].v) begin
        check("B_key", ev_key, tbl[i].key);
        check("B_code", ev_code, tbl[i].code);
      end
      check("B_overflow", overflow, 1'b0);
    end

    // C: stalled consumer, FIFO fills, drop sets overflow, ovf_clr clears it
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    check("C_overflow_before_drop", overflow, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("C_overflow_set", overflow, 1'b1);
    for (int s = 0; s < 3; s++) begin
      check("C_hold_valid", ev_valid, 1'b1);
      check("C_hold_key", ev_key, 2'd0);
      check("C_hold_code", ev_code, 2'd0);
      step(4'b0000, 1'b0, 1'b0, 1'b1);
    end
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    check("C_overflow_clr", overflow, 1'b0);
    obs.delete();
    rec = 1'b1;
    for (int s = 0; s < 8; s++) step(4'b0000, 1'b1, 1'b0, 1'b1);
    rec = 1'b0;
    exp_q = {};
    exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(0, 3));
    exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(1, 3));
    exp_q.push_back(mk(2, 0));
    check_obs("C_drain", exp_q);

    // D: short tap on key2
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    obs.delete();
    rec = 1'b1;
    for (int s = 0; s < 15; s++) step((s < 3) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, 1'b1);
    rec = 1'b0;
    exp_q = {};
    exp_q.push_back(mk(2, 0)); exp_q.push_back(mk(2, 3));
    check_obs("D_tap", exp_q);

    // E: key3 released exactly at the LONG threshold
    obs.delete();
    rec = 1'b1;
    for (int s = 0; s < 18; s++) step((s < L) ? 4'b1000 : 4'b0000, 1'b1, 1'b0, 1'b1);
    rec = 1'b0;
    exp_q = {};
    exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(3, 3));
    check_obs("E_edge", exp_q);

    // F: reset with events queued and key1 held
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    check("F_queued_valid", ev_valid, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    check("F_rst_valid", ev_valid, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    check("F_e0_valid", ev_valid, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    check("F_e1_valid", ev_valid, 1'b1);
    check("F_e1_key", ev_key, 2'd1);
    check("F_e1_code", ev_code, 2'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b1);

    // random phase, model-checked every cycle
    lv = 4'b0000;
    rdy_pct = 50;
    for (int s = 0; s < 4000; s++) begin
      if (s % 200 == 0) rdy_pct = $urandom_range(5, 95);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) lv[k] = ~lv[k];
      step(lv, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
